// File: rtl/ql_beep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ql_beep_sequencer
// Description : Plays one QL BEEP command. Sweeps a pitch between two limits
//               at a programmable rate, adds LFSR fuzz, and stops after a
//               programmed duration or on request. Drives the freq/fuzz
//               inputs of the downstream square-wave tone generator.
// Revision    : 1.0 - initial release
// ============================================================================
module ql_beep_sequencer #(
  parameter int TICK_CYCLES = 1944
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_pitch1,
  input  logic [7:0]  i_pitch2,
  input  logic [15:0] i_grad_x,
  input  logic [3:0]  i_grad_y,
  input  logic [3:0]  i_wrap,
  input  logic [3:0]  i_fuzz_in,
  input  logic [15:0] i_duration,
  input  logic        i_stop,
  output logic [8:0]  o_freq,
  output logic [7:0]  o_fuzz,
  output logic        o_busy,
  output logic        o_done
);

  // Prescaler width; TICK_CYCLES is at least 2 so the width is at least 1.
  localparam int C_PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [C_PW-1:0] C_TICK_LAST = C_PW'(TICK_CYCLES - 1);
  localparam logic [15:0]     C_LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t r_state;

  // Registered copy of the accepted command
  logic [7:0]  r_pitch1;
  logic [7:0]  r_pitch2;
  logic [15:0] r_grad_x;
  logic [3:0]  r_grad_y;
  logic [3:0]  r_wrap;
  logic [3:0]  r_fuzz_w;
  logic [15:0] r_duration;

  // Playback state
  logic [7:0]      r_cur;
  logic [C_PW-1:0] r_presc;
  logic [15:0]     r_step_cnt;
  logic [15:0]     r_dur_cnt;
  logic [3:0]      r_wrap_cnt;
  logic            r_frozen;
  logic [15:0]     r_lfsr;

  // Registered outputs
  logic [8:0] r_freq;
  logic [7:0] r_fuzz;
  logic       r_busy;
  logic       r_done;
  logic       r_cmd_ready;

  // Combinational helpers
  logic        w_accept;
  logic        w_tick;
  logic        w_lfsr_fb;
  logic [15:0] w_lfsr_next;
  logic [7:0]  w_mask;
  logic [15:0] w_dur_next;
  logic        w_dur_end;
  logic        w_sweep;
  logic [15:0] w_step_next;
  logic        w_step_fire;
  logic [7:0]  w_lo;
  logic [7:0]  w_hi;
  logic [9:0]  w_next10;
  logic        w_in_range;
  logic [3:0]  w_wrap_next;
  logic        w_freeze;
  logic [7:0]  w_cur_next;

  // Handshake and tick generation
  always_comb begin
    w_accept = i_cmd_valid && r_cmd_ready;
    w_tick   = (r_state == S_PLAY) && (r_presc == C_TICK_LAST);
  end

  // Fuzz source: left-shifting Fibonacci LFSR, taps x^16+x^14+x^13+x^11,
  // and a fuzz mask of min(fuzz_in,8) low bits.
  always_comb begin
    w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    w_lfsr_next = {r_lfsr[14:0], w_lfsr_fb};
    if (r_fuzz_w[3]) begin
      w_mask = 8'hFF;
    end else begin
      w_mask = 8'((9'd1 << r_fuzz_w[2:0]) - 9'd1);
    end
  end

  // Duration and sweep-rate counters, evaluated for the current tick
  always_comb begin
    w_dur_next  = r_dur_cnt + 16'd1;
    w_dur_end   = w_tick && (r_duration != 16'd0) && (w_dur_next == r_duration);
    w_sweep     = (r_grad_x != 16'd0) && (r_grad_y != 4'd0) && !r_frozen;
    w_step_next = r_step_cnt + 16'd1;
    w_step_fire = w_tick && w_sweep && (w_step_next == r_grad_x);
  end

  // Pitch step: 10-bit signed add, out-of-range results wrap back to pitch1
  always_comb begin
    w_lo        = (r_pitch1 < r_pitch2) ? r_pitch1 : r_pitch2;
    w_hi        = (r_pitch1 < r_pitch2) ? r_pitch2 : r_pitch1;
    w_next10    = {2'b00, r_cur} + {{6{r_grad_y[3]}}, r_grad_y};
    // Bits 9:8 clear means the result is non-negative and fits in 8 bits.
    w_in_range  = (w_next10[9:8] == 2'b00) &&
                  (w_next10[7:0] >= w_lo) && (w_next10[7:0] <= w_hi);
    w_wrap_next = r_wrap_cnt + 4'd1;
    w_freeze    = (r_wrap != 4'd0) && (w_wrap_next == r_wrap);
    w_cur_next  = w_in_range ? w_next10[7:0] : r_pitch1;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pitch1    <= 8'd0;
      r_pitch2    <= 8'd0;
      r_grad_x    <= 16'd0;
      r_grad_y    <= 4'd0;
      r_wrap      <= 4'd0;
      r_fuzz_w    <= 4'd0;
      r_duration  <= 16'd0;
      r_cur       <= 8'd0;
      r_presc     <= '0;
      r_step_cnt  <= 16'd0;
      r_dur_cnt   <= 16'd0;
      r_wrap_cnt  <= 4'd0;
      r_frozen    <= 1'b0;
      r_lfsr      <= C_LFSR_SEED;
      r_freq      <= 9'd0;
      r_fuzz      <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      // The LFSR runs on every tick so the fuzz pattern keeps evolving
      // across consecutive tones.
      if (w_tick) begin
        r_lfsr <= w_lfsr_next;
      end

      if (w_accept) begin
        // New command wins over stop and duration end; a preempted tone
        // finishes silently without a done pulse.
        r_pitch1    <= i_pitch1;
        r_pitch2    <= i_pitch2;
        r_grad_x    <= i_grad_x;
        r_grad_y    <= i_grad_y;
        r_wrap      <= i_wrap;
        r_fuzz_w    <= i_fuzz_in;
        r_duration  <= i_duration;
        r_busy      <= 1'b1;
        r_cmd_ready <= 1'b0;
        r_state     <= S_LOAD;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end

          S_LOAD: begin
            r_cur       <= r_pitch1;
            r_presc     <= '0;
            r_step_cnt  <= 16'd0;
            r_dur_cnt   <= 16'd0;
            r_wrap_cnt  <= 4'd0;
            r_frozen    <= 1'b0;
            r_freq      <= {1'b0, r_pitch1};
            r_cmd_ready <= 1'b1;
            r_state     <= S_PLAY;
          end

          S_PLAY: begin
            if (i_stop || w_dur_end) begin
              r_freq  <= 9'd0;
              r_fuzz  <= 8'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_presc <= w_tick ? '0 : (r_presc + C_PW'(1));
              if (w_tick) begin
                r_fuzz    <= w_lfsr_next[7:0] & w_mask;
                r_dur_cnt <= w_dur_next;
                if (w_sweep) begin
                  if (w_step_fire) begin
                    r_step_cnt <= 16'd0;
                    r_cur      <= w_cur_next;
                    r_freq     <= {1'b0, w_cur_next};
                    if (!w_in_range) begin
                      r_wrap_cnt <= w_wrap_next;
                      if (w_freeze) begin
                        r_frozen <= 1'b1;
                      end
                    end
                  end else begin
                    r_step_cnt <= w_step_next;
                  end
                end
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_freq      = r_freq;
  assign o_fuzz      = r_fuzz;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cmd_ready = r_cmd_ready;

endmodule
`default_nettype wire

// File: tb/tb_ql_beep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ql_beep_sequencer
// Description : Scoreboard bench for ql_beep_sequencer (TICK_CYCLES=4).
//               Stimulus pushes expected output events (cycle, freq, fuzz,
//               done); a monitor pops one whenever any of those outputs
//               changes and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ql_beep_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  pitch1;
  logic [7:0]  pitch2;
  logic [15:0] grad_x;
  logic [3:0]  grad_y;
  logic [3:0]  wrap;
  logic [3:0]  fuzz_in;
  logic [15:0] duration;
  logic        stop;
  logic [8:0]  freq;
  logic [7:0]  fuzz;
  logic        busy;
  logic        done;

  ql_beep_sequencer #(.TICK_CYCLES(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_pitch1    (pitch1),
    .i_pitch2    (pitch2),
    .i_grad_x    (grad_x),
    .i_grad_y    (grad_y),
    .i_wrap      (wrap),
    .i_fuzz_in   (fuzz_in),
    .i_duration  (duration),
    .i_stop      (stop),
    .o_freq      (freq),
    .o_fuzz      (fuzz),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cy;
    logic [8:0]  f;
    logic [7:0]  z;
    logic        d;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  logic [8:0] p_f;
  logic [7:0] p_z;
  logic       p_d;

  // Monitor: every change of freq/fuzz/done must match the next expected event
  always @(negedge clk) begin
    if (mon_en) begin
      if (freq !== p_f || fuzz !== p_z || done !== p_d) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d freq=%0d fuzz=%0h done=%0b", cyc, freq, fuzz, done);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.cy != 32'(cyc) || e.f !== freq || e.z !== fuzz || e.d !== done) begin
            bad++;
            $display("FAIL event got cyc=%0d freq=%0d fuzz=%0h done=%0b want cyc=%0d freq=%0d fuzz=%0h done=%0b",
                     cyc, freq, fuzz, done, e.cy, e.f, e.z, e.d);
          end
        end
      end
      p_f = freq;
      p_z = fuzz;
      p_d = done;
    end
  end

  task automatic ev(input int cy, input int f, input int z, input bit d);
    ev_t e;
    e.cy = 32'(cy);
    e.f  = 9'(f);
    e.z  = 8'(z);
    e.d  = d;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Presents a command for one cycle; c is the cycle count at presentation,
  // so acceptance happens at edge c+1 and pitch1 shows at cycle c+2.
  task automatic issue(input int p1, input int p2, input int gx, input int gy,
                       input int wr, input int fz, input int dur, input bit with_stop,
                       output int c);
    @(negedge clk);
    pitch1    = 8'(p1);
    pitch2    = 8'(p2);
    grad_x    = 16'(gx);
    grad_y    = 4'(gy);
    wrap      = 4'(wr);
    fuzz_in   = 4'(fz);
    duration  = 16'(dur);
    stop      = with_stop;
    cmd_valid = 1'b1;
    c = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int c2;
    reset = 1'b1; cmd_valid = 1'b0; stop = 1'b0;
    pitch1 = 8'd0; pitch2 = 8'd0; grad_x = 16'd0; grad_y = 4'd0;
    wrap = 4'd0; fuzz_in = 4'd0; duration = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_freq", 32'(freq), 32'd0);
    chk("rst_fuzz", 32'(fuzz), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    p_f = freq; p_z = fuzz; p_d = done;
    mon_en = 1'b1;

    // Fixed tone, duration 3 ticks
    issue(100, 0, 0, 0, 0, 0, 3, 1'b0, c);
    ev(c+2, 100, 0, 0); ev(c+14, 0, 0, 1); ev(c+15, 0, 0, 0);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("play_ready", 32'(cmd_ready), 32'd1);
    chk("play_busy", 32'(busy), 32'd1);
    wait_until(c+14);
    chk("end_busy", 32'(busy), 32'd0);
    wait_until(c+20);

    // Up-sweep 10..13, unlimited wrap, ended by stop
    issue(10, 13, 1, 1, 0, 0, 0, 1'b0, c);
    ev(c+2, 10, 0, 0); ev(c+6, 11, 0, 0); ev(c+10, 12, 0, 0); ev(c+14, 13, 0, 0);
    ev(c+18, 10, 0, 0); ev(c+22, 11, 0, 0);
    ev(c+25, 0, 0, 1); ev(c+26, 0, 0, 0);
    wait_until(c+24);
    pulse_stop();
    wait_until(c+26);
    chk("stop_busy", 32'(busy), 32'd0);
    wait_until(c+30);

    // Up-sweep with wrap=2: freezes at pitch1 after the second wrap
    issue(10, 13, 1, 1, 2, 0, 0, 1'b0, c);
    ev(c+2, 10, 0, 0); ev(c+6, 11, 0, 0); ev(c+10, 12, 0, 0); ev(c+14, 13, 0, 0);
    ev(c+18, 10, 0, 0); ev(c+22, 11, 0, 0); ev(c+26, 12, 0, 0); ev(c+30, 13, 0, 0);
    ev(c+34, 10, 0, 0);
    ev(c+51, 0, 0, 1); ev(c+52, 0, 0, 0);
    wait_until(c+48);
    chk("frozen_freq", 32'(freq), 32'd10);
    wait_until(c+50);
    pulse_stop();
    wait_until(c+56);

    // Down-sweep 13..10, then preempted by a new command (no done)
    issue(13, 10, 1, -1, 0, 0, 0, 1'b0, c);
    ev(c+2, 13, 0, 0); ev(c+6, 12, 0, 0); ev(c+10, 11, 0, 0); ev(c+14, 10, 0, 0);
    ev(c+18, 13, 0, 0);
    wait_until(c+19);
    issue(50, 0, 0, 0, 0, 0, 0, 1'b0, c2);
    chk("preempt_cyc", 32'(c2), 32'(c+20));
    ev(c2+2, 50, 0, 0);
    wait_until(c2+6);

    // Stop and command in the same cycle: command wins, then ends after 2 ticks
    issue(77, 0, 0, 0, 0, 0, 2, 1'b1, c);
    ev(c+2, 77, 0, 0); ev(c+10, 0, 0, 1); ev(c+11, 0, 0, 0);
    wait_until(c+16);

    // Reset in the middle of a tone: outputs clear, no done
    issue(60, 0, 0, 0, 0, 0, 0, 1'b0, c);
    ev(c+2, 60, 0, 0); ev(c+6, 0, 0, 0);
    wait_until(c+5);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;

    // fuzz_in=3 from seed: LFSR 59C3 -> 3, B387 -> 7
    issue(20, 0, 0, 0, 0, 3, 3, 1'b0, c);
    ev(c+2, 20, 0, 0); ev(c+6, 20, 3, 0); ev(c+10, 20, 7, 0);
    ev(c+14, 0, 0, 1); ev(c+15, 0, 0, 0);
    wait_until(c+18);

    // fuzz_in=12 acts as 8 bits, after re-seeding via reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(30, 0, 0, 0, 0, 12, 0, 1'b0, c);
    ev(c+2, 30, 0, 0); ev(c+6, 30, 8'hC3, 0); ev(c+10, 30, 8'h87, 0);
    ev(c+13, 0, 0, 1); ev(c+14, 0, 0, 0);
    wait_until(c+12);
    pulse_stop();
    wait_until(c+24);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ql_beep_sequencer.md
# ql_beep_sequencer

Plays one QL BEEP command by sequencing pitch and fuzz over time. It sits directly upstream of the square-wave tone generator and drives that block's `freq` and `fuzz` inputs. It accepts one command through a valid/ready handshake and sweeps the pitch between two limits at a programmable rate. It stops after a programmed duration or on request, and signals completion with a one-cycle pulse.

## Interface
- `TICK_CYCLES`, 1944: clk cycles per sequencer tick (72 µs at 27 MHz). Must be ≥2.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted.
- `pitch1` in 8: start pitch.
- `pitch2` in 8: second sweep limit.
- `grad_x` in 16: ticks per pitch step; 0 means no sweep.
- `grad_y` in 4: signed step added per sweep step; 0 means no sweep.
- `wrap` in 4: number of wrap-arounds before the pitch freezes; 0 means unlimited.
- `fuzz_in` in 4: fuzz width in bits; values ≥8 are treated as 8.
- `duration` in 16: tone length in ticks; 0 means play until stopped.
- `stop` in 1: abort the current tone.
- `freq` out 9: to tone generator; 0 means silence.
- `fuzz` out 8: to tone generator.
- `busy` out 1: high in LOAD or PLAY.
- `done` out 1: one-cycle pulse on normal end or on stop.

## Operation
- States are IDLE, LOAD and PLAY. Reset forces IDLE.
- Reset values: `freq`=0, `fuzz`=0, `busy`=0, `done`=0, `cmd_ready`=1, LFSR=16'hACE1.
- `cmd_ready` is low only in LOAD. A command is accepted when `cmd_valid` and `cmd_ready` are both high at a rising edge, in either IDLE or PLAY. Acceptance in PLAY preempts the current tone, and no `done` pulse is produced for the preempted tone.
- On acceptance, all command fields are registered and the state moves to LOAD.
- LOAD lasts exactly one cycle. It loads the current pitch with `pitch1` and clears the prescaler, step, duration and wrap counters. It drives `freq`={1'b0,`pitch1`}. The state then moves to PLAY.
- Tick prescaler:
  - Counts 0..`TICK_CYCLES`-1 while in PLAY.
  - `tick` is asserted in the cycle the count equals `TICK_CYCLES`-1, and the count then wraps to 0.
- On each tick in PLAY:
  - Advance the LFSR. It uses taps x^16+x^14+x^13+x^11 and shifts left.
  - Update `fuzz` to lfsr[7:0] AND mask, where mask=(1<<min(`fuzz_in`,8))-1. `fuzz_in`=0 therefore gives `fuzz`=0.
  - Increment the duration counter. If `duration`≠0 and the counter reaches `duration`, the tone ends (see below).
  - If sweeping (`grad_x`≠0 and `grad_y`≠0) and not frozen, increment the step counter. When it reaches `grad_x`, clear it and apply a step.
- Step arithmetic:
  - next = current + sign-extended `grad_y`, computed as 10-bit signed.
  - lo = min(`pitch1`,`pitch2`), hi = max(`pitch1`,`pitch2`).
  - If lo ≤ next ≤ hi, current becomes next.
  - Otherwise the pitch wraps to `pitch1` and the wrap counter increments. If `wrap`≠0 and the wrap counter equals `wrap`, the pitch is frozen at `pitch1` for the rest of the tone.
- In PLAY, `freq`={1'b0,current}. A current pitch of 0 gives silence for that step.
- Tone end (duration reached or `stop`):
  - The next edge sets `freq`=0 and `fuzz`=0 and moves the state to IDLE.
  - `done`=1 for exactly one cycle.
- Priority within a cycle: `reset` > command acceptance > `stop` > duration end.
- `stop` in IDLE or LOAD is ignored.

## Timing
- Command accepted at edge T:
  - `busy`=1 and `cmd_ready`=0 after T.
  - `freq`=`pitch1` after edge T+1.
  - `cmd_ready` returns to 1 after T+1.
- First tick occurs `TICK_CYCLES` cycles after entering PLAY.
- With `duration`=D≠0, `freq` drops to 0 and `done` pulses D·`TICK_CYCLES` cycles after `freq` first shows `pitch1`.
- `stop` sampled high at edge S: `freq`=0, `busy`=0 and `done`=1 after S.
- A pitch change appears on `freq` on the edge following the tick that completes a step.
- Reset asserted mid-PLAY: all outputs return to their reset values after that edge, with no `done` pulse.

## Test plan
- Reset with stray `cmd_valid`=0 -> `freq`=0, `fuzz`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- `TICK_CYCLES`=4, `pitch1`=100, `grad_y`=0, `duration`=3 -> `freq`=100 for 12 cycles starting 2 cycles after acceptance, then `freq`=0, then a single `done` pulse.
- `TICK_CYCLES`=4, `pitch1`=10, `pitch2`=13, `grad_x`=1, `grad_y`=+1, `wrap`=0, `duration`=0 -> `freq` sequence 10,11,12,13,10,11… with each value held 4 cycles, continuing indefinitely.
- Same setup with `wrap`=2 -> 10..13, 10..13, then `freq` held at 10. Repeat with `grad_y`=-1 and `pitch1`=13, `pitch2`=10 -> 13,12,11,10,13,…
- `stop` pulse mid-tone -> `freq`=0 next cycle and `done` pulses once. A new command during PLAY -> `freq` jumps to the new `pitch1` with no `done` pulse. `stop` and `cmd_valid` in the same cycle -> the command wins.
- `fuzz_in`=0 -> `fuzz` stays 0. `fuzz_in`=3 -> `fuzz` ≤7, changes only on ticks, and its first value matches the LFSR advanced once from 16'hACE1. `fuzz_in`=12 -> behaves as 8.
